// File: rtl/traffic_controller_multi.sv
// Multi-road traffic light controller with ambulance preemption,
// night flashing mode and a violation warning/counter side channel.
module traffic_controller_multi #(
   parameter int N_ROADS  = 4,
   parameter int T_GREEN  = 100,
   parameter int T_YELLOW = 20,
   parameter int T_ALLRED = 5,
   parameter int T_FLASH  = 5,
   parameter int T_VIOL   = 10
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_ROADS-1:0]         amb_req,
   input  logic                       night_mode,
   input  logic                       violation_force,
   output logic [2:0]                 state_out,
   output logic [$clog2(N_ROADS)-1:0] active_road,
   output logic [2*N_ROADS-1:0]       lights,
   output logic                       violation_warning,
   output logic [7:0]                 violation_count
);

   localparam int AW = $clog2(N_ROADS);
   localparam int LW = 2 * N_ROADS;

   localparam logic [31:0] LD_GREEN  = 32'(T_GREEN - 1);
   localparam logic [31:0] LD_YELLOW = 32'(T_YELLOW - 1);
   localparam logic [31:0] LD_ALLRED = 32'(T_ALLRED - 1);
   localparam logic [31:0] LD_FLASH  = 32'(T_FLASH - 1);
   localparam logic [31:0] LD_VIOL   = 32'(T_VIOL - 1);

   localparam logic [1:0] LT_YEL = 2'b01;
   localparam logic [1:0] LT_GRN = 2'b10;

   localparam logic [LW-1:0] ALL_RED = '0;
   localparam logic [LW-1:0] ALL_YEL = {N_ROADS{2'b01}};
   localparam logic [LW-1:0] ALL_OFF = {N_ROADS{2'b11}};

   typedef enum logic [2:0] {
      S_GREEN  = 3'd0,
      S_YELLOW = 3'd1,
      S_ALLRED = 3'd2,
      S_AMB    = 3'd3,
      S_NIGHT  = 3'd4
   } state_t;

   state_t         state;
   logic [31:0]    timer;
   logic [AW-1:0]  next_road;
   logic [AW-1:0]  amb_road;
   logic [N_ROADS-1:0] act_mask;
   logic           amb_any;
   logic           amb_mine;
   logic           amb_other;
   logic           tmr_zero;
   logic           green_exit;

   logic           vf_prev;
   logic           vf_rise;
   logic [31:0]    viol_tmr;

   // Road r shows code c, every other road red.
   function automatic logic [LW-1:0] one_lit(
      input logic [AW-1:0] r,
      input logic [1:0]    c
   );
      logic [LW-1:0] l;
      l = '0;
      l[2*int'(r) +: 2] = c;
      return l;
   endfunction

   function automatic logic [AW-1:0] lowest(
      input logic [N_ROADS-1:0] r
   );
      logic [AW-1:0] idx;
      idx = '0;
      for (int i = N_ROADS - 1; i >= 0; i--) begin
         if (r[i]) idx = AW'(i);
      end
      return idx;
   endfunction

   always_comb begin
      act_mask   = N_ROADS'(1) << active_road;
      amb_any    = |amb_req;
      amb_mine   = |(amb_req & act_mask);
      amb_other  = |(amb_req & ~act_mask);
      tmr_zero   = (timer == '0);
      amb_road   = lowest(amb_req);
      next_road  = (active_road == AW'(N_ROADS - 1)) ?
                   '0 : active_road + 1'b1;
      // Extension by the own-road ambulance masks the timeout.
      green_exit = amb_other | night_mode |
                   (~amb_mine & tmr_zero);
   end

   assign state_out = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_GREEN;
         active_road <= '0;
         timer       <= LD_GREEN;
         lights      <= one_lit('0, LT_GRN);
      end else begin
         unique case (state)
            S_GREEN: begin
               if (green_exit) begin
                  state  <= S_YELLOW;
                  timer  <= LD_YELLOW;
                  lights <= one_lit(active_road, LT_YEL);
               end else if (amb_mine) begin
                  timer <= LD_GREEN;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            S_YELLOW: begin
               if (tmr_zero) begin
                  state  <= S_ALLRED;
                  timer  <= LD_ALLRED;
                  lights <= ALL_RED;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            S_ALLRED: begin
               if (!tmr_zero) begin
                  timer <= timer - 32'd1;
               end else if (amb_any) begin
                  state       <= S_AMB;
                  active_road <= amb_road;
                  lights      <= one_lit(amb_road, LT_GRN);
               end else if (night_mode) begin
                  state  <= S_NIGHT;
                  timer  <= LD_FLASH;
                  lights <= ALL_YEL;
               end else begin
                  state       <= S_GREEN;
                  active_road <= next_road;
                  timer       <= LD_GREEN;
                  lights      <= one_lit(next_road, LT_GRN);
               end
            end
            S_AMB: begin
               if (!amb_mine) begin
                  state  <= S_YELLOW;
                  timer  <= LD_YELLOW;
                  lights <= one_lit(active_road, LT_YEL);
               end
            end
            S_NIGHT: begin
               if (!night_mode || amb_any) begin
                  state  <= S_ALLRED;
                  timer  <= LD_ALLRED;
                  lights <= ALL_RED;
               end else if (tmr_zero) begin
                  timer  <= LD_FLASH;
                  lights <= (lights == ALL_YEL) ? ALL_OFF : ALL_YEL;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            default: begin
               state  <= S_ALLRED;
               timer  <= LD_ALLRED;
               lights <= ALL_RED;
            end
         endcase
      end
   end

   assign vf_rise = violation_force & ~vf_prev;

   // Warning hold restarts on every new rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vf_prev           <= 1'b0;
         violation_warning <= 1'b0;
         viol_tmr          <= '0;
         violation_count   <= '0;
      end else begin
         vf_prev <= violation_force;
         if (vf_rise) begin
            violation_warning <= 1'b1;
            viol_tmr          <= LD_VIOL;
            if (violation_count != 8'hFF)
               violation_count <= violation_count + 8'd1;
         end else if (violation_warning) begin
            if (viol_tmr == '0)
               violation_warning <= 1'b0;
            else
               viol_tmr <= viol_tmr - 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_traffic_controller_multi.sv
// Directed self-checking bench for traffic_controller_multi
// (N_ROADS=4, T_GREEN=10, T_YELLOW=3, T_ALLRED=2, T_FLASH=2, T_VIOL=4).
module tb_traffic_controller_multi;

   logic       clk;
   logic       reset_n;
   logic [3:0] amb_req;
   logic       night_mode;
   logic       violation_force;
   logic [2:0] state_out;
   logic [1:0] active_road;
   logic [7:0] lights;
   logic       violation_warning;
   logic [7:0] violation_count;

   int n_cmp;
   int n_err;

   logic [12:0] obs;
   logic [8:0]  vobs;
   assign obs  = {state_out, active_road, lights};
   assign vobs = {violation_warning, violation_count};

   traffic_controller_multi #(
      .N_ROADS (4),
      .T_GREEN (10),
      .T_YELLOW(3),
      .T_ALLRED(2),
      .T_FLASH (2),
      .T_VIOL  (4)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .amb_req          (amb_req),
      .night_mode       (night_mode),
      .violation_force  (violation_force),
      .state_out        (state_out),
      .active_road      (active_road),
      .lights           (lights),
      .violation_warning(violation_warning),
      .violation_count  (violation_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] pk(
      input logic [2:0] s,
      input logic [1:0] r,
      input logic [7:0] l
   );
      return {s, r, l};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n         = 1'b0;
      amb_req         = '0;
      night_mode      = 1'b0;
      violation_force = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n         = 1'b0;
      amb_req         = '0;
      night_mode      = 1'b0;
      violation_force = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (obs !== pk(3'd0, 2'd0, 8'h02)) begin
         n_err++;
         $display("FAIL reset_fsm got %h exp %h", obs, pk(3'd0, 2'd0, 8'h02));
      end
      n_cmp++;
      if (vobs !== 9'h000) begin
         n_err++;
         $display("FAIL reset_viol got %h exp %h", vobs, 9'h000);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_normal_cycle();
      logic [12:0] e;
      int road, ph;
      do_reset();
      for (int k = 0; k <= 60; k++) begin
         if (k > 0) tick();
         road = (k / 15) % 4;
         ph   = k % 15;
         if (ph < 10)
            e = pk(3'd0, 2'(road), 8'h02 << (2 * road));
         else if (ph < 13)
            e = pk(3'd1, 2'(road), 8'h01 << (2 * road));
         else
            e = pk(3'd2, 2'(road), 8'h00);
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL normal k=%0d got %h exp %h", k, obs, e);
         end
      end
   endtask

   task automatic test_amb_preempt();
      logic [12:0] e;
      do_reset();
      for (int k = 0; k <= 21; k++) begin
         if (k > 0) tick();
         if (k <= 4)       e = pk(3'd0, 2'd0, 8'h02);
         else if (k <= 7)  e = pk(3'd1, 2'd0, 8'h01);
         else if (k <= 9)  e = pk(3'd2, 2'd0, 8'h00);
         else if (k <= 15) e = pk(3'd3, 2'd2, 8'h20);
         else if (k <= 18) e = pk(3'd1, 2'd2, 8'h10);
         else if (k <= 20) e = pk(3'd2, 2'd2, 8'h00);
         else              e = pk(3'd0, 2'd3, 8'h80);
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL amb_preempt k=%0d got %h exp %h", k, obs, e);
         end
         if (k == 4)  amb_req = 4'b0100;
         if (k == 15) amb_req = 4'b0000;
      end
   endtask

   task automatic test_amb_multi();
      logic [12:0] e;
      do_reset();
      for (int k = 0; k <= 29; k++) begin
         if (k > 0) tick();
         if (k <= 9)       e = pk(3'd0, 2'd0, 8'h02);
         else if (k <= 12) e = pk(3'd1, 2'd0, 8'h01);
         else if (k <= 14) e = pk(3'd2, 2'd0, 8'h00);
         else if (k <= 17) e = pk(3'd3, 2'd1, 8'h08);
         else if (k <= 20) e = pk(3'd1, 2'd1, 8'h04);
         else if (k <= 22) e = pk(3'd2, 2'd1, 8'h00);
         else if (k == 23) e = pk(3'd3, 2'd3, 8'h80);
         else if (k <= 26) e = pk(3'd1, 2'd3, 8'h40);
         else if (k <= 28) e = pk(3'd2, 2'd3, 8'h00);
         else              e = pk(3'd0, 2'd0, 8'h02);
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL amb_multi k=%0d got %h exp %h", k, obs, e);
         end
         if (k == 13) amb_req = 4'b1010;
         if (k == 17) amb_req = 4'b1000;
         if (k == 23) amb_req = 4'b0000;
      end
   endtask

   task automatic test_night();
      logic [12:0] e;
      do_reset();
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) tick();
         if (k <= 2)       e = pk(3'd0, 2'd0, 8'h02);
         else if (k <= 5)  e = pk(3'd1, 2'd0, 8'h01);
         else if (k <= 7)  e = pk(3'd2, 2'd0, 8'h00);
         else if (k <= 9)  e = pk(3'd4, 2'd0, 8'h55);
         else if (k <= 11) e = pk(3'd4, 2'd0, 8'hFF);
         else if (k <= 13) e = pk(3'd4, 2'd0, 8'h55);
         else if (k <= 15) e = pk(3'd2, 2'd0, 8'h00);
         else              e = pk(3'd0, 2'd1, 8'h08);
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL night k=%0d got %h exp %h", k, obs, e);
         end
         if (k == 2)  night_mode = 1'b1;
         if (k == 13) night_mode = 1'b0;
      end
   endtask

   task automatic test_violation();
      logic [8:0] e;
      do_reset();
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) tick();
         e[8]   = (k >= 6 && k <= 11);
         e[7:0] = (k < 6) ? 8'd0 : (k < 8) ? 8'd1 : 8'd2;
         n_cmp++;
         if (vobs !== e) begin
            n_err++;
            $display("FAIL viol k=%0d got %h exp %h", k, vobs, e);
         end
         if (k == 5) violation_force = 1'b1;
         if (k == 6) violation_force = 1'b0;
         if (k == 7) violation_force = 1'b1;
         if (k == 8) violation_force = 1'b0;
      end
      for (int p = 0; p < 300; p++) begin
         violation_force = 1'b1;
         tick();
         violation_force = 1'b0;
         tick();
      end
      n_cmp++;
      if (violation_count !== 8'd255) begin
         n_err++;
         $display("FAIL viol_sat got %0d exp %0d", violation_count, 255);
      end
   endtask

   task automatic test_reset_mid_amb();
      logic [12:0] e;
      do_reset();
      amb_req = 4'b0010;
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) violation_force = 1'b1;
         if (k == 3) violation_force = 1'b0;
         tick();
         if (k <= 3)      e = pk(3'd1, 2'd0, 8'h01);
         else if (k <= 5) e = pk(3'd2, 2'd0, 8'h00);
         else             e = pk(3'd3, 2'd1, 8'h08);
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL rst_amb_pre k=%0d got %h exp %h", k, obs, e);
         end
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== pk(3'd0, 2'd0, 8'h02)) begin
         n_err++;
         $display("FAIL rst_amb_fsm got %h exp %h", obs, pk(3'd0, 2'd0, 8'h02));
      end
      n_cmp++;
      if (vobs !== 9'h000) begin
         n_err++;
         $display("FAIL rst_amb_viol got %h exp %h", vobs, 9'h000);
      end
      amb_req = '0;
      tick();
      reset_n = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) tick();
         e = (k < 10) ? pk(3'd0, 2'd0, 8'h02) : pk(3'd1, 2'd0, 8'h01);
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL rst_amb_post k=%0d got %h exp %h", k, obs, e);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_normal_cycle();
      test_amb_preempt();
      test_amb_multi();
      test_night();
      test_violation();
      test_reset_mid_amb();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/traffic_controller_multi.md
TRAFFIC_CONTROLLER_MULTI -- requirements
Module: traffic_controller_multi

Interface
REQ-001 SHALL have parameter N_ROADS, default 4, number of approach roads (legal 2..8).
REQ-002 SHALL have parameter T_GREEN, default 100, normal green duration in cycles (>=2).
REQ-003 SHALL have parameter T_YELLOW, default 20, yellow duration in cycles (>=1).
REQ-004 SHALL have parameter T_ALLRED, default 5, all-red clearance duration in cycles (>=1).
REQ-005 SHALL have parameter T_FLASH, default 5, night-flash half-period in cycles (>=1).
REQ-006 SHALL have parameter T_VIOL, default 10, violation-warning hold in cycles (>=1).
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port amb_req, input, N_ROADS, per-road ambulance request, bit i = road i.
REQ-010 SHALL have port night_mode, input, 1, night flashing request.
REQ-011 SHALL have port violation_force, input, 1, violation event input.
REQ-012 SHALL have port state_out, output, 3, current FSM state code.
REQ-013 SHALL have port active_road, output, clog2(N_ROADS), road owning current green/yellow.
REQ-014 SHALL have port lights, output, 2*N_ROADS, road i at bits [2i+1:2i]; 00 red, 01 yellow, 10 green, 11 off.
REQ-015 SHALL have port violation_warning, output, 1, warning active.
REQ-016 SHALL have port violation_count, output, 8, saturating violation event count.

Function
REQ-017 SHALL encode states GREEN=0, YELLOW=1, ALLRED=2, AMB_GREEN=3, NIGHT=4; codes 5-7 unreachable, recover to ALLRED.
REQ-018 SHALL use one down-counter timer loaded with duration-1 on state entry; a timed state exits on the edge where timer==0, so it lasts exactly its duration.
REQ-019 SHALL drive all outputs from registers; lights, state_out, active_road change on the same edge as the state.
REQ-020 GREEN: active_road green, others red; exit to YELLOW at timer 0, or on the next edge when any amb_req bit not equal to active_road is set, or when night_mode is 1.
REQ-021 GREEN with amb_req[active_road]=1 SHALL reload timer to T_GREEN-1 each cycle (green extended).
REQ-022 YELLOW: active_road yellow, others red; exit to ALLRED at timer 0; not preemptible.
REQ-023 ALLRED: all roads red; at timer 0, priority: any amb_req -> AMB_GREEN on lowest set index; else night_mode -> NIGHT; else GREEN on next road.
REQ-024 Next road SHALL be (active_road+1) mod N_ROADS, wrapping N_ROADS-1 to 0; after AMB_GREEN, next road follows the ambulance road.
REQ-025 AMB_GREEN: active_road green, others red, untimed; exit to YELLOW on the edge amb_req[active_road] samples 0.
REQ-026 NIGHT: all roads toggle between 01 and 11 every T_FLASH cycles, starting 01; exit to ALLRED when night_mode=0 or any amb_req set (amb has priority in following ALLRED).
REQ-027 A rising edge of violation_force (registered compare against previous sample) SHALL set violation_warning for exactly T_VIOL cycles starting the next cycle; a new edge while active restarts the hold.
REQ-028 Each rising edge SHALL increment violation_count, saturating at 255; violation logic is independent of FSM state.
REQ-029 Simultaneous amb_req on several roads SHALL serve only the lowest index; others are served at later ALLRED decisions if still asserted.

Reset
REQ-030 reset_n low SHALL immediately force state GREEN, active_road 0, timer T_GREEN-1, lights road 0 green others red, violation_warning 0, violation_count 0, edge-detect register 0.
REQ-031 Reset asserted mid-operation (any state, incl. AMB_GREEN or NIGHT) SHALL discard all pending behaviour; operation resumes from REQ-030 values on the first edge after release.

Verification (N_ROADS=4, T_GREEN=10, T_YELLOW=3, T_ALLRED=2, T_FLASH=2, T_VIOL=4)
REQ-032 No inputs after reset -> road0 green 10 cycles, yellow 3, all-red 2, road1 green; road3 wraps to road0; full cycle 60 cycles.
REQ-033 amb_req=4'b0100 at cycle 4 of road0 green -> YELLOW next edge, 3 yellow, 2 all-red, road2 green held until deassert, then yellow, all-red, road3 green.
REQ-034 amb_req=4'b1010 during ALLRED before road1 -> road1 served; road3 served after if still asserted.
REQ-035 night_mode=1 in GREEN -> yellow, all-red, lights alternate 0x55/0xFF every 2 cycles; night_mode=0 -> all-red 2 cycles, green on next road.
REQ-036 violation_force pulses at cycles 5 and 7 -> warning high cycles 6-11, count=2; 300 pulses -> count=255.
REQ-037 reset_n low during AMB_GREEN -> outputs at REQ-030 values same cycle, ambulance not resumed.
